urp_pcie_rx_ack_scheduler: RTL and testbench

//  Schedules ACK/NAK DLLPs for the RX data link layer (DLL). Tracks good and bad TLP events with their
//  12-bit sequence numbers and coalesces ACKs by count or timeout. Issues one NAK per error episode.

---
 rtl/urp_pcie_rx_ack_scheduler.sv | 170 +++++++++++++++++
 tb/tb_urp_pcie_rx_ack_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/urp_pcie_rx_ack_scheduler.sv
// RX DLL ACK/NAK scheduler: coalesces ACKs by count/timeout, one NAK per error episode.
// Optional statistics counters are enabled with `define URP_PCIE_ACK_STATS_EN.
module urp_pcie_rx_ack_scheduler #(
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 64,
  parameter int SEQ_W        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tlp_good_i,
  input  logic [SEQ_W-1:0] tlp_seq_i,
  input  logic             tlp_bad_i,
  output logic [31:0]      dllp_o,
  output logic             dllp_valid_o,
  input  logic             dllp_read_i,
  output logic [15:0]      ack_cnt_o,
  output logic [15:0]      nak_cnt_o
);

  localparam logic [7:0]  COAL_MAX = 8'(ACK_COALESCE);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [7:0]  DLLP_ACK = 8'h00;
  localparam logic [7:0]  DLLP_NAK = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PENDING,
    S_SEND_ACK,
    S_SEND_NAK,
    S_NAK_SCHED
  } state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] last_seq_q, last_seq_d;
  logic [7:0]       pend_q, pend_d, pend_inc;
  logic [15:0]      timer_q, timer_d;
  logic             nak_due_q, nak_due_d;
  logic             valid_q, valid_d;
  logic [31:0]      dllp_q, dllp_d;
  logic             good, bad, rd;
  logic             load_ack, load_nak;

  always_comb begin
    // A bad TLP in the same cycle as a good one swallows the good event.
    good       = tlp_good_i & ~tlp_bad_i;
    bad        = tlp_bad_i;
    rd         = dllp_read_i & valid_q;
    last_seq_d = good ? tlp_seq_i : last_seq_q;
    pend_inc   = (good && pend_q != COAL_MAX) ? pend_q + 8'd1 : pend_q;

    state_d   = state_q;
    pend_d    = pend_inc;
    timer_d   = timer_q;
    nak_due_d = nak_due_q;
    valid_d   = valid_q;
    dllp_d    = dllp_q;
    load_ack  = 1'b0;
    load_nak  = 1'b0;

    case (state_q)
      S_IDLE, S_NAK_SCHED: begin
        if (bad && state_q == S_IDLE) begin
          load_nak = 1'b1;
        end else if (good) begin
          pend_d  = 8'd1;
          timer_d = 16'd0;
          if (COAL_MAX == 8'd1) load_ack = 1'b1;
          else                  state_d  = S_PENDING;
        end
      end
      S_PENDING: begin
        timer_d = timer_q + 16'd1;
        if (bad)                                          load_nak = 1'b1;
        else if (pend_inc == COAL_MAX || timer_d == TMO_LAST) load_ack = 1'b1;
      end
      S_SEND_ACK: begin
        timer_d = 16'd0;
        if (bad) nak_due_d = 1'b1;
        // An ACK already on the wire is always delivered; a NAK queued behind it follows.
        if (rd) begin
          if (bad || nak_due_q)          load_nak = 1'b1;
          else if (pend_inc == COAL_MAX) load_ack = 1'b1;
          else begin
            valid_d = 1'b0;
            state_d = (pend_inc != 8'd0) ? S_PENDING : S_IDLE;
          end
        end
      end
      S_SEND_NAK: begin
        timer_d = 16'd0;
        if (rd) begin
          pend_d  = 8'd0;
          valid_d = 1'b0;
          state_d = S_NAK_SCHED;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (load_ack) begin
      state_d = S_SEND_ACK;
      valid_d = 1'b1;
      pend_d  = 8'd0;
      timer_d = 16'd0;
      dllp_d  = {DLLP_ACK, 12'h000, 12'(last_seq_d)};
    end
    if (load_nak) begin
      state_d   = S_SEND_NAK;
      valid_d   = 1'b1;
      nak_due_d = 1'b0;
      timer_d   = 16'd0;
      dllp_d    = {DLLP_NAK, 12'h000, 12'(last_seq_d)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_seq_q <= '1;
      pend_q     <= 8'd0;
      timer_q    <= 16'd0;
      nak_due_q  <= 1'b0;
      valid_q    <= 1'b0;
      dllp_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_seq_q <= last_seq_d;
      pend_q     <= pend_d;
      timer_q    <= timer_d;
      nak_due_q  <= nak_due_d;
      valid_q    <= valid_d;
      dllp_q     <= dllp_d;
    end
  end

  assign dllp_o       = dllp_q;
  assign dllp_valid_o = valid_q;

`ifdef URP_PCIE_ACK_STATS_EN
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [15:0] nak_cnt_q, nak_cnt_d;

  always_comb begin
    ack_cnt_d = ack_cnt_q;
    nak_cnt_d = nak_cnt_q;
    if (rd && state_q == S_SEND_ACK && ack_cnt_q != 16'hFFFF) ack_cnt_d = ack_cnt_q + 16'd1;
    if (rd && state_q == S_SEND_NAK && nak_cnt_q != 16'hFFFF) nak_cnt_d = nak_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt_q <= 16'd0;
      nak_cnt_q <= 16'd0;
    end else begin
      ack_cnt_q <= ack_cnt_d;
      nak_cnt_q <= nak_cnt_d;
    end
  end

  assign ack_cnt_o = ack_cnt_q;
  assign nak_cnt_o = nak_cnt_q;
`else
  assign ack_cnt_o = 16'h0000;
  assign nak_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_urp_pcie_rx_ack_scheduler.sv
// Directed bench for urp_pcie_rx_ack_scheduler (default parameters 4/64/12).
module tb_urp_pcie_rx_ack_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tlp_good_i;
  logic [11:0] tlp_seq_i;
  logic        tlp_bad_i;
  logic [31:0] dllp_o;
  logic        dllp_valid_o;
  logic        dllp_read_i;
  logic [15:0] ack_cnt_o;
  logic [15:0] nak_cnt_o;

  int n_total = 0;
  int n_bad   = 0;
  int n;

  urp_pcie_rx_ack_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tlp_good_i   (tlp_good_i),
    .tlp_seq_i    (tlp_seq_i),
    .tlp_bad_i    (tlp_bad_i),
    .dllp_o       (dllp_o),
    .dllp_valid_o (dllp_valid_o),
    .dllp_read_i  (dllp_read_i),
    .ack_cnt_o    (ack_cnt_o),
    .nak_cnt_o    (nak_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("check %s ok value=%h", tag, got);
    end
  endtask

  // Inputs present before the edge are consumed by it; outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_good(input logic [11:0] seq);
    tlp_good_i = 1'b1;
    tlp_seq_i  = seq;
    step();
    tlp_good_i = 1'b0;
  endtask

  task automatic send_bad();
    tlp_bad_i = 1'b1;
    step();
    tlp_bad_i = 1'b0;
  endtask

  // Counts cycles until valid rises, bounded at 200.
  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (!dllp_valid_o && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_ack, exp_nak;
    rst_n = 1'b0; tlp_good_i = 1'b0; tlp_seq_i = 12'h000; tlp_bad_i = 1'b0; dllp_read_i = 1'b0;
    step(); step();
    check("rst_valid", {31'd0, dllp_valid_o}, 32'd0);
    check("rst_dllp", dllp_o, 32'd0);
    check("rst_cnt", {ack_cnt_o, nak_cnt_o}, 32'd0);
    rst_n = 1'b1;
    step();

    // T1 coalesce
    dllp_read_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_good(12'(i));
      if (i < 3) check($sformatf("t1_quiet%0d", i), {31'd0, dllp_valid_o}, 32'd0);
    end
    check("t1_valid", {31'd0, dllp_valid_o}, 32'd1);
    check("t1_dllp", dllp_o, 32'h0000_0003);
    step();
    check("t1_one_beat", {31'd0, dllp_valid_o}, 32'd0);

    // T3 single NAK per episode, then recovery
    send_good(12'h005);
    send_bad();
    check("t3_nak_valid", {31'd0, dllp_valid_o}, 32'd1);
    check("t3_nak_dllp", dllp_o, 32'h1000_0005);
    step();
    check("t3_nak_drop", {31'd0, dllp_valid_o}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      send_bad();
      step();
      check($sformatf("t3_ignore%0d", i), {31'd0, dllp_valid_o}, 32'd0);
    end
    for (int i = 6; i <= 9; i++) send_good(12'(i));
    check("t3_ack_valid", {31'd0, dllp_valid_o}, 32'd1);
    check("t3_ack_dllp", dllp_o, 32'h0000_0009);
    step();
    check("t3_ack_drop", {31'd0, dllp_valid_o}, 32'd0);

    // T6 statistics after T1+T3
`ifdef URP_PCIE_ACK_STATS_EN
    exp_ack = 16'd2; exp_nak = 16'd1;
`else
    exp_ack = 16'd0; exp_nak = 16'd0;
`endif
    check("t6_ack_cnt", {16'd0, ack_cnt_o}, {16'd0, exp_ack});
    check("t6_nak_cnt", {16'd0, nak_cnt_o}, {16'd0, exp_nak});

    // T2 timeout: valid exactly 64 cycles after the good
    send_good(12'h010);
    wait_valid(n);
    check("t2_latency", 32'(n), 32'd64);
    check("t2_dllp", dllp_o, 32'h0000_0010);
    step();
    check("t2_drop", {31'd0, dllp_valid_o}, 32'd0);

    // T4 backpressure
    dllp_read_i = 1'b0;
    for (int i = 3; i <= 6; i++) send_good(12'(i));
    check("t4_valid", {31'd0, dllp_valid_o}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 2) send_good(12'h007);
      else if (c == 5) send_good(12'h008);
      else step();
      check($sformatf("t4_hold%0d", c), {dllp_valid_o, dllp_o[30:0]}, 32'h8000_0006);
    end
    dllp_read_i = 1'b1;
    step();
    check("t4_read_drop", {31'd0, dllp_valid_o}, 32'd0);
    wait_valid(n);
    check("t4_pend_latency", 32'(n), 32'd64);
    check("t4_pend_dllp", dllp_o, 32'h0000_0008);
    step();

    // T5 good+bad together: NAK carries the previous seq
    tlp_good_i = 1'b1; tlp_seq_i = 12'h123; tlp_bad_i = 1'b1;
    step();
    tlp_good_i = 1'b0; tlp_bad_i = 1'b0;
    check("t5_both_dllp", {dllp_valid_o, dllp_o[30:0]}, 32'h9000_0008);
    step();

    // T5 sequence wrap
    send_good(12'hFFE); send_good(12'hFFF); send_good(12'h000); send_good(12'h001);
    check("t5_wrap_dllp", {dllp_valid_o, dllp_o[30:0]}, 32'h8000_0001);
    step();

    // T5 asynchronous reset while a DLLP is waiting
    dllp_read_i = 1'b0;
    for (int i = 20; i <= 23; i++) send_good(12'(i));
    check("t5_pre_rst", {dllp_valid_o, dllp_o[30:0]}, 32'h8000_0017);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, dllp_valid_o}, 32'd0);
    check("t5_rst_cnt", {ack_cnt_o, nak_cnt_o}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    dllp_read_i = 1'b1;
    step(); step(); step();
    check("t5_no_replay", {31'd0, dllp_valid_o}, 32'd0);
    send_bad();
    check("t5_rst_seq", {dllp_valid_o, dllp_o[30:0]}, 32'h9000_0FFF);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
